// File: rtl/shared_reg_arbiter.sv
// Two-requester write arbiter for one shared register built from d_ff cells.
// Define SHARED_REG_ROUND_ROBIN_EN for round-robin ties; default is fixed priority.

module d_ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module shared_reg_arbiter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     data0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     data1,
    output logic                 ack1,
    output logic [WIDTH-1:0]     q,
    output logic                 owner,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] write_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 grant_valid;
    logic                 grant_idx;
    logic                 grant_en;
    logic                 load_en;
    logic [WIDTH-1:0]     load_data;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 tie_winner;

`ifdef SHARED_REG_ROUND_ROBIN_EN
    logic last_grant;

    // Reset value 1 lets requester 0 win the first tie.
    d_ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_last_grant (
        .clk   (clk),
        .reset (reset),
        .en    (grant_en),
        .d     (grant_idx),
        .q     (last_grant)
    );

    assign tie_winner = ~last_grant;
`else
    assign tie_winner = 1'b0;
`endif

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        unique case (1'b1)
            (req0 & ~req1): begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            (~req0 & req1): begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            (req0 & req1): begin
                grant_valid = 1'b1;
                grant_idx   = tie_winner;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = S_IDLE;
        unique case (state)
            S_IDLE:  state_nxt = grant_valid ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign grant_en  = (state == S_IDLE) & grant_valid;
    assign load_en   = (state == S_LOAD);
    assign load_data = owner ? data1 : data0;
    assign count_nxt = write_count + CNT_WIDTH'(1);

    d_ff #(
        .WIDTH   (2),
        .RST_VAL (S_IDLE)
    ) u_state (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (state_nxt),
        .q     (state)
    );

    d_ff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_owner (
        .clk   (clk),
        .reset (reset),
        .en    (grant_en),
        .d     (grant_idx),
        .q     (owner)
    );

    d_ff #(
        .WIDTH   (WIDTH),
        .RST_VAL ('0)
    ) u_shared_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load_en),
        .d     (load_data),
        .q     (q)
    );

    d_ff #(
        .WIDTH   (CNT_WIDTH),
        .RST_VAL ('0)
    ) u_write_count (
        .clk   (clk),
        .reset (reset),
        .en    (load_en),
        .d     (count_nxt),
        .q     (write_count)
    );

    assign busy = (state != S_IDLE);
    assign ack0 = (state == S_ACK) & ~owner;
    assign ack1 = (state == S_ACK) & owner;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, single writes, ties,
// reset abort and counter wrap, with hand-computed expectations.

module tb_shared_reg_arbiter;

    logic       clk;
    logic       reset;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic [7:0] q;
    logic       owner;
    logic       busy;
    logic [3:0] write_count;

    int         n_checks;
    int         n_errors;
    logic [3:0] exp_cnt;

    shared_reg_arbiter #(
        .WIDTH     (8),
        .CNT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .data1       (data1),
        .ack1        (ack1),
        .q           (q),
        .owner       (owner),
        .busy        (busy),
        .write_count (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic single_write(input logic idx, input logic [7:0] d);
        @(negedge clk);
        if (idx) begin
            req1  = 1'b1;
            data1 = d;
        end else begin
            req0  = 1'b1;
            data0 = d;
        end
        @(negedge clk);
        check("sw_busy_load", busy, 1);
        check("sw_noack_load", ack0 | ack1, 0);
        @(negedge clk);
        exp_cnt = exp_cnt + 4'd1;
        check("sw_ack0", ack0, !idx);
        check("sw_ack1", ack1, idx);
        check("sw_q", q, d);
        check("sw_count", write_count, exp_cnt);
        check("sw_owner", owner, idx);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("sw_idle_busy", busy, 0);
        check("sw_idle_noack", ack0 | ack1, 0);
    endtask

    initial begin
        int n_ack0;
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 4'd0;
        reset    = 1'b1;
        req0     = 1'b1;
        req1     = 1'b1;
        data0    = 8'h55;
        data1    = 8'hAA;

        repeat (2) @(negedge clk);
        check("rst_q", q, 0);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_count", write_count, 0);
        check("rst_owner", owner, 0);

        // Request 1 granted, then reset lands on the LOAD edge.
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b1;
        data1 = 8'h3C;
        @(negedge clk);
        check("abort_busy_load", busy, 1);
        check("abort_owner", owner, 1);
        reset = 1'b1;
        req1  = 1'b0;
        @(negedge clk);
        check("abort_q", q, 0);
        check("abort_count", write_count, 0);
        check("abort_busy", busy, 0);
        check("abort_ack1", ack1, 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_ack1", ack1, 0);
            check("abort_idle", busy, 0);
        end

        single_write(1'b0, 8'hA5);
        single_write(1'b1, 8'h5A);

`ifdef SHARED_REG_ROUND_ROBIN_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 4'd0;
        data0   = 8'h11;
        data1   = 8'h22;
        for (int r = 0; r < 2; r++) begin
            req0 = 1'b1;
            req1 = 1'b1;
            @(negedge clk);
            check("rr_busy0", busy, 1);
            check("rr_owner0", owner, 0);
            @(negedge clk);
            exp_cnt = exp_cnt + 4'd1;
            check("rr_ack0", ack0, 1);
            check("rr_ack1_low", ack1, 0);
            check("rr_q0", q, 8'h11);
            check("rr_cnt0", write_count, exp_cnt);
            req0 = 1'b0;
            @(negedge clk);
            check("rr_idle0", busy, 0);
            @(negedge clk);
            check("rr_busy1", busy, 1);
            check("rr_owner1", owner, 1);
            check("rr_q_hold", q, 8'h11);
            @(negedge clk);
            exp_cnt = exp_cnt + 4'd1;
            check("rr_ack1", ack1, 1);
            check("rr_ack0_low", ack0, 0);
            check("rr_q1", q, 8'h22);
            check("rr_cnt1", write_count, exp_cnt);
            req1 = 1'b0;
            @(negedge clk);
            check("rr_idle1", busy, 0);
        end
`else
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        req0   = 1'b1;
        req1   = 1'b1;
        data0  = 8'h11;
        data1  = 8'h22;
        n_ack0 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("fp_ack1_starved", ack1, 0);
            if (ack0) begin
                n_ack0++;
                req0 = 1'b0;
            end else begin
                req0 = 1'b1;
            end
        end
        check("fp_ack0_count", n_ack0, 10);
        check("fp_q", q, 8'h11);
        check("fp_count", write_count, 10);
`endif

        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            single_write(i[0], 8'h10 + 8'(i));
        end
        check("wrap_count", write_count, 1);
        check("wrap_q", q, 8'h20);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
